// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // Ops that the sequencer can accept (arith or HI/LO moves).
    function automatic logic is_acceptable(md_op_e op);
        return (op >= MD_MULT) && (op <= MD_MTLO);
    endfunction

    function automatic logic is_div(md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU handshake and data bundle.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    md_op_e      md_op;
    logic        start;
    logic        flush;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        stall_req;
    logic [31:0] mdm_rd;

    modport master (
        output md_op, start, flush, rs_val, rt_val,
        input  busy, stall_req, mdm_rd
    );

    modport slave (
        input  md_op, start, flush, rs_val, rt_val,
        output busy, stall_req, mdm_rd
    );

endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational 32x32 multiply and divide producing a {hi, lo} pair.
module mdu_ctrl_arith
    import mdu_ctrl_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] prod;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        sgn;

    // Signed divide runs on magnitudes then restores signs; this also gives
    // 0x8000_0000 / -1 = 0x8000_0000 rem 0 without a special case.
    always_comb begin
        sgn  = (op == MD_DIV);
        dvd  = (sgn && rs[31]) ? (~rs + 32'd1) : rs;
        dvs  = (sgn && rt[31]) ? (~rt + 32'd1) : rt;
        quo  = dvd / dvs;
        rem  = dvd % dvs;
        if (sgn && (rs[31] ^ rt[31])) begin
            quo = ~quo + 32'd1;
        end
        if (sgn && rs[31]) begin
            rem = ~rem + 32'd1;
        end
        prod = (op == MD_MULT) ? ({{32{rs[31]}}, rs} * {{32{rt[31]}}, rt})
                               : ({32'd0, rs} * {32'd0, rt});
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            MD_MULT, MD_MULTU: {hi, lo} = prod;
            MD_DIV, MD_DIVU: begin
                if (rt == 32'd0) begin
                    hi = rs;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    hi = rem;
                    lo = quo;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models fixed latency, drives MF read path.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no op in flight; accepts MULT*/DIV*/MTHI/MTLO
//  ST_RUN   | arith op in flight; cnt counts down, commit on cnt 1->0
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      reset_n,
    mdu_ctrl_if.slave md
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [31:0] res_hi, res_lo;
    logic        accept;

    mdu_ctrl_arith u_arith (
        .op (md.md_op),
        .rs (md.rs_val),
        .rt (md.rt_val),
        .hi (res_hi),
        .lo (res_lo)
    );

    // Flush only gates new work; an op already in RUN always retires.
    assign accept = md.start & ~md.flush & (state_q == ST_IDLE) & is_acceptable(md.md_op);

    // Next-state: accept from IDLE, count down in RUN, commit on terminal count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (md.md_op)
                        MD_MTHI: hi_d = md.rs_val;
                        MD_MTLO: lo_d = md.rs_val;
                        default: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            cnt_d     = is_div(md.md_op) ? DIV_CNT : MULT_CNT;
                            busy_d    = 1'b1;
                            state_d   = ST_RUN;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter, HI/LO and pending result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign md.busy      = busy_q;
    assign md.stall_req = (md.md_op != MD_NONE) & busy_q;

    // Read path always shows architectural HI/LO, never the pending result.
    always_comb begin
        case (md.md_op)
            MD_MFHI: md.mdm_rd = hi_q;
            MD_MFLO: md.mdm_rd = lo_q;
            default: md.mdm_rd = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table, corner sequences, random vs model.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int unsigned m_pend;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        flush;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [3:0] op, logic fl, logic [31:0] rs,
                                logic [31:0] rt, logic [31:0] hi, logic [31:0] lo, int cyc);
        vec_t v;
        v.name = n; v.op = op; v.flush = fl; v.rs = rs; v.rt = rt;
        v.hi = hi; v.lo = lo; v.cyc = cyc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_pend = 0; m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0;
    endfunction

    function automatic void model_edge(logic [3:0] op, logic st, logic fl,
                                       logic [31:0] rs, logic [31:0] rt);
        longint          sp;
        longint unsigned up;
        int              a, b;
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (st && !fl) begin
            case (op)
                4'd1: begin
                    sp = longint'(int'(rs)) * longint'(int'(rt));
                    {m_phi, m_plo} = sp;
                    m_pend = 5;
                end
                4'd2: begin
                    up = longint'({32'd0, rs}) * longint'({32'd0, rt});
                    {m_phi, m_plo} = up;
                    m_pend = 5;
                end
                4'd3: begin
                    a = int'(rs); b = int'(rt);
                    if (b == 0) begin
                        m_plo = 32'hFFFF_FFFF; m_phi = rs;
                    end else if (a == int'(32'h8000_0000) && b == -1) begin
                        m_plo = 32'h8000_0000; m_phi = 32'd0;
                    end else begin
                        m_plo = a / b; m_phi = a % b;
                    end
                    m_pend = 10;
                end
                4'd4: begin
                    if (rt == 32'd0) begin
                        m_plo = 32'hFFFF_FFFF; m_phi = rs;
                    end else begin
                        m_plo = rs / rt; m_phi = rs % rt;
                    end
                    m_pend = 10;
                end
                4'd5: m_hi = rs;
                4'd6: m_lo = rs;
                default: ;
            endcase
        end
    endfunction

    task automatic drive(input logic [3:0] op, input logic st, input logic fl,
                         input logic [31:0] rs, input logic [31:0] rt);
        bus.md_op  = md_op_e'(op);
        bus.start  = st;
        bus.flush  = fl;
        bus.rs_val = rs;
        bus.rt_val = rt;
    endtask

    // Apply inputs for one clock; returns at the following negedge.
    task automatic step(input logic [3:0] op, input logic st, input logic fl,
                        input logic [31:0] rs, input logic [31:0] rt);
        drive(op, st, fl, rs, rt);
        @(posedge clk);
        model_edge(op, st, fl, rs, rt);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_rd;
        logic        exp_busy;
        exp_busy = (m_pend != 0);
        exp_rd   = (bus.md_op == MD_MFHI) ? m_hi : (bus.md_op == MD_MFLO) ? m_lo : 32'd0;
        chk({tag, " busy"}, 32'(bus.busy), 32'(exp_busy));
        chk({tag, " stall"}, 32'(bus.stall_req), 32'(exp_busy && (bus.md_op != MD_NONE)));
        chk({tag, " rd"}, bus.mdm_rd, exp_rd);
    endtask

    // Run NONE/flush cycles until busy drops; returns busy-cycle count incl. current sample.
    task automatic wait_idle(input logic fl_all, input int flush_at, input string tag,
                             output int n);
        n = 0;
        while (bus.busy && n < 20) begin
            n++;
            step(4'd0, 1'b0, fl_all || (n == flush_at), 32'd0, 32'd0);
            check_model(tag);
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        step(4'd7, 1'b0, 1'b0, 32'd0, 32'd0);
        chk({tag, " hi"}, bus.mdm_rd, hi);
        step(4'd8, 1'b0, 1'b0, 32'd0, 32'd0);
        chk({tag, " lo"}, bus.mdm_rd, lo);
    endtask

    // A start while busy can never be legal: the stall holds it in E.
    always @(posedge clk) begin
        if (reset_n === 1'b1) begin
            assert (!(bus.start && bus.busy && bus.md_op >= MD_MULT && bus.md_op <= MD_MTLO))
            else begin
                n_bad++;
                $display("FAIL start_while_busy: got start=1 busy=1 expected no start");
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] prev_lo;
        logic        hold_ok;
        logic [31:0] a, b;
        logic [63:0] p;
        logic [3:0]  r_op;
        logic        r_st, r_fl;
        logic [31:0] r_rs, r_rt;

        // reset state, async
        reset_n = 1'b0;
        drive(4'd7, 1'b0, 1'b0, 32'd0, 32'd0);
        model_reset();
        #2;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst hi", bus.mdm_rd, 32'd0);
        drive(4'd8, 1'b0, 1'b0, 32'd0, 32'd0);
        #1 chk("rst lo", bus.mdm_rd, 32'd0);
        drive(4'd1, 1'b1, 1'b0, 32'd3, 32'd4);
        #1 chk("rst stall", 32'(bus.stall_req), 32'd0);
        drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        vecs.push_back(mk("mult_neg",  4'd1, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5));
        vecs.push_back(mk("divu_100_7",4'd4, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 10));
        vecs.push_back(mk("div_m7_2",  4'd3, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10));
        vecs.push_back(mk("div_by0",   4'd3, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10));
        vecs.push_back(mk("div_ovf",   4'd3, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10));
        vecs.push_back(mk("divu_by0",  4'd4, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10));
        vecs.push_back(mk("mthi_fl",   4'd5, 1'b1, 32'h1234, 32'd0, 32'd5, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk("mthi",      4'd5, 1'b0, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk("mtlo",      4'd6, 1'b0, 32'hCAFE, 32'd0, 32'h1234, 32'hCAFE, 0));
        vecs.push_back(mk("multu_max", 4'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 5));
        vecs.push_back(mk("mult_min2", 4'd1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 5));
        vecs.push_back(mk("div_7_m2",  4'd3, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10));
        vecs.push_back(mk("mult_fl",   4'd1, 1'b1, 32'd2, 32'd3, 32'd1, 32'hFFFF_FFFD, 0));
        vecs.push_back(mk("divu_big",  4'd4, 1'b0, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 10));

        prev_lo = 32'd0;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].op, 1'b1, vecs[i].flush, vecs[i].rs, vecs[i].rt);
            n = 0;
            hold_ok = 1'b1;
            while (bus.busy && n < 20) begin
                n++;
                step(4'd8, 1'b0, 1'b0, 32'd0, 32'd0);
                if (bus.busy && (bus.stall_req !== 1'b1 || bus.mdm_rd !== prev_lo))
                    hold_ok = 1'b0;
            end
            chk({vecs[i].name, " cycles"}, 32'(n), 32'(vecs[i].cyc));
            chk({vecs[i].name, " hold"}, 32'(hold_ok), 32'd1);
            read_hilo(vecs[i].name, vecs[i].hi, vecs[i].lo);
            prev_lo = vecs[i].lo;
        end

        // flush pulse during busy cycle 2 does not abort MULTU
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        p = {32'd0, a} * {32'd0, b};
        step(4'd2, 1'b1, 1'b0, a, b);
        wait_idle(1'b0, 2, "multu_flush", n);
        chk("multu_flush cycles", 32'(n), 32'd5);
        read_hilo("multu_flush", p[63:32], p[31:0]);

        // flush held through the terminal-count edge still commits
        step(4'd3, 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7);
        wait_idle(1'b1, 0, "div_flush", n);
        chk("div_flush cycles", 32'(n), 32'd10);
        read_hilo("div_flush", 32'hFFFF_FFFE, 32'hFFFF_FFF2);

        // reset at busy cycle 3 abandons the op
        step(4'd1, 1'b1, 1'b0, 32'd3, 32'd4);
        step(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("pre_rst busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        drive(4'd7, 1'b0, 1'b0, 32'd0, 32'd0);
        model_reset();
        #1;
        chk("mid_rst busy", 32'(bus.busy), 32'd0);
        chk("mid_rst hi", bus.mdm_rd, 32'd0);
        drive(4'd8, 1'b0, 1'b0, 32'd0, 32'd0);
        #1 chk("mid_rst lo", bus.mdm_rd, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(4'd8, 1'b0, 1'b0, 32'd0, 32'd0);
            check_model("post_rst");
        end
        read_hilo("post_rst", 32'd0, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r_op = 4'($urandom_range(0, 8));
            r_st = (m_pend == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            r_fl = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       r_rs = 32'($urandom_range(0, 200));
                1:       r_rs = 32'h8000_0000;
                default: r_rs = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       r_rt = 32'd0;
                1:       r_rt = 32'hFFFF_FFFF;
                2:       r_rt = 32'($urandom_range(1, 20));
                default: r_rt = $urandom;
            endcase
            step(r_op, r_st, r_fl, r_rs, r_rt);
            check_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
